// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Datapath pipeline stage register with valid/ready flow control, flush and a
// saturating stall counter. Carries NCH data words of WIDTH bits plus one
// WIDTH1-bit tag field between two CPU datapath stages.
//
// Optional feature macro: PIPE_SKID_EN
//   defined   : 1-entry skid register; in_ready is registered (~skid_valid),
//               so there is no out_ready -> in_ready combinational path.
//               Up to 2 words held, order preserved.
//   undefined : no skid; in_ready = ~out_valid | out_ready. Max 1 word held.
//
// Ports:
//   clk        in   1          clock, rising edge
//   reset      in   1          asynchronous, active-high reset
//   flush      in   1          synchronous kill of all held entries
//   in_valid   in   1          upstream has a word
//   in_ready   out  1          stage can accept a word this cycle
//   d_data     in   NCH*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
//   d_tag      in   WIDTH1     tag field
//   out_valid  out  1          q_data/q_tag hold a live word
//   out_ready  in   1          downstream accepts this cycle
//   q_data     out  NCH*WIDTH  registered data, same packing as d_data
//   q_tag      out  WIDTH1     registered tag
//   stall_cnt  out  CNT_W      cycles with out_valid=1 and out_ready=0
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned WIDTH1 = 4,
    parameter int unsigned NCH    = 3,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NCH*WIDTH-1:0]   d_data,
    input  logic [WIDTH1-1:0]      d_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NCH*WIDTH-1:0]   q_data,
    output logic [WIDTH1-1:0]      q_tag,
    output logic [CNT_W-1:0]       stall_cnt
);

    localparam int unsigned DW = NCH * WIDTH;

    logic [CNT_W-1:0] cnt_one;
    assign cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    // Output register
    logic              out_valid_q, out_valid_d;
    logic [DW-1:0]     data_q,      data_d;
    logic [WIDTH1-1:0] tag_q,       tag_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic xfer_in;
    logic xfer_out;

`ifdef PIPE_SKID_EN
    // Skid entry: holds the word accepted while the output register stalls.
    logic              skid_valid_q, skid_valid_d;
    logic [DW-1:0]     skid_data_q,  skid_data_d;
    logic [WIDTH1-1:0] skid_tag_q,   skid_tag_d;

    // Ready depends only on state and flush, never on out_ready.
    always_comb begin
        in_ready = ~skid_valid_q & ~flush;
        xfer_in  = in_valid & in_ready;
        xfer_out = out_valid_q & out_ready;
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        data_d       = data_q;
        tag_d        = tag_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_tag_d   = skid_tag_q;

        if (flush) begin
            // flush dominates any load or refill; q_* keep their value.
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // A full skid implies a live output word and in_ready=0, so the
            // only possible move is a refill once downstream drains.
            if (out_ready) begin
                data_d       = skid_data_q;
                tag_d        = skid_tag_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end
        end else if (xfer_in) begin
            if (~out_valid_q | out_ready) begin
                data_d      = d_data;
                tag_d       = d_tag;
                out_valid_d = 1'b1;
            end else begin
                skid_data_d  = d_data;
                skid_tag_d   = d_tag;
                skid_valid_d = 1'b1;
            end
        end else if (xfer_out) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_tag_q   <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_tag_q   <= skid_tag_d;
        end
    end
`else
    always_comb begin
        in_ready = ~flush & (~out_valid_q | out_ready);
        xfer_in  = in_valid & in_ready;
        xfer_out = out_valid_q & out_ready;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        data_d      = data_q;
        tag_d       = tag_q;

        // in_ready is already 0 under flush, so xfer_in cannot load then.
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (xfer_in) begin
            data_d      = d_data;
            tag_d       = d_tag;
            out_valid_d = 1'b1;
        end else if (xfer_out) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    // Saturating stall counter; only reset clears it.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q & ~out_ready & (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + cnt_one;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            data_q      <= '0;
            tag_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            tag_q       <= tag_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign q_data    = data_q;
    assign q_tag     = tag_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Self-checking bench for pipe_stage_reg (WIDTH=8, WIDTH1=4, NCH=3, CNT_W=4).
// The reference model treats the stage as a FIFO of held words (capacity 1,
// or 2 with PIPE_SKID_EN) plus the last word shown on q_*.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int unsigned W   = 8;
    localparam int unsigned W1  = 4;
    localparam int unsigned N   = 3;
    localparam int unsigned CW  = 4;
    localparam int unsigned DW  = N * W;
`ifdef PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] d_data;
    logic [W1-1:0] d_tag;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] q_data;
    logic [W1-1:0] q_tag;
    logic [CW-1:0] stall_cnt;

    pipe_stage_reg #(
        .WIDTH  (W),
        .WIDTH1 (W1),
        .NCH    (N),
        .CNT_W  (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d_data    (d_data),
        .d_tag     (d_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q_data    (q_data),
        .q_tag     (q_tag),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp;
    int unsigned n_bad;

    // ---------------- reference model ----------------
    logic [DW+W1-1:0] mq[$];
    logic [DW+W1-1:0] m_shown;
    int unsigned      m_cnt;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pk(input logic [7:0] x);
        pk = {x + 8'd2, x + 8'd1, x};
    endfunction

    function automatic logic m_in_ready();
        if (flush) return 1'b0;
        if (SKID) return mq.size() < 2;
        return (mq.size() == 0) || out_ready;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_shown = '0;
        m_cnt   = 0;
    endtask

    task automatic model_check();
        check("m_out_valid", 32'(out_valid), 32'(mq.size() > 0));
        check("m_in_ready",  32'(in_ready),  32'(m_in_ready()));
        check("m_q_data",    32'(q_data),    32'(m_shown[DW-1:0]));
        check("m_q_tag",     32'(q_tag),     32'(m_shown[DW+W1-1:DW]));
        check("m_stall_cnt", 32'(stall_cnt), m_cnt);
    endtask

    task automatic model_edge();
        logic acc;
        acc = in_valid && m_in_ready();
        if (mq.size() > 0 && !out_ready && m_cnt < (2**CW) - 1) m_cnt++;
        if (flush) begin
            mq.delete();
        end else begin
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            if (acc) mq.push_back({d_tag, d_data});
        end
        if (mq.size() > 0) m_shown = mq[0];
    endtask

    // ---------------- drivers ----------------
    task automatic drive(input logic fl, input logic iv, input logic [DW-1:0] d,
                         input logic [W1-1:0] t, input logic ordy);
        flush     = fl;
        in_valid  = iv;
        d_data    = d;
        d_tag     = t;
        out_ready = ordy;
        @(negedge clk);
        model_check();
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic fl, input logic iv, input logic [DW-1:0] d,
                        input logic [W1-1:0] t, input logic ordy);
        drive(fl, iv, d, t, ordy);
        tick();
    endtask

    task automatic do_reset();
        flush     = 1'b0;
        in_valid  = 1'b0;
        d_data    = '0;
        d_tag     = '0;
        out_ready = 1'b0;
        reset     = 1'b1;
        model_reset();
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        logic       fl;
        logic       iv;
        logic [7:0] d;
        logic [3:0] t;
        logic       ordy;
        logic       e_ov;
        logic       e_ir;
        logic [7:0] e_q;
        logic [3:0] e_t;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;

        // Streaming with full throughput, drain, and a dropped flush word.
        vecs[0] = '{1'b0, 1'b1, 8'h11, 4'h1, 1'b1, 1'b0, 1'b1, 8'h00, 4'h0};
        vecs[1] = '{1'b0, 1'b1, 8'h22, 4'h2, 1'b1, 1'b1, 1'b1, 8'h11, 4'h1};
        vecs[2] = '{1'b0, 1'b1, 8'h33, 4'h3, 1'b1, 1'b1, 1'b1, 8'h22, 4'h2};
        vecs[3] = '{1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b1, 1'b1, 8'h33, 4'h3};
        vecs[4] = '{1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 1'b1, 8'h33, 4'h3};
        vecs[5] = '{1'b1, 1'b1, 8'h44, 4'h4, 1'b1, 1'b0, 1'b0, 8'h33, 4'h3};
        vecs[6] = '{1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 1'b1, 8'h33, 4'h3};

        // Reset state
        do_reset();
        drive(1'b0, 1'b0, '0, 4'h0, 1'b0);
        check("rst_q_data",    32'(q_data),    32'h0);
        check("rst_q_tag",     32'(q_tag),     32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_in_ready",  32'(in_ready),  32'h1);
        check("rst_stall_cnt", 32'(stall_cnt), 32'h0);
        tick();

        // Table vectors
        for (int unsigned i = 0; i < 7; i++) begin
            drive(vecs[i].fl, vecs[i].iv, pk(vecs[i].d), vecs[i].t, vecs[i].ordy);
            check($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            check($sformatf("tbl%0d_in_ready", i),  32'(in_ready),  32'(vecs[i].e_ir));
            check($sformatf("tbl%0d_q_ch0", i),     32'(q_data[7:0]), 32'(vecs[i].e_q));
            check($sformatf("tbl%0d_q_tag", i),     32'(q_tag),     32'(vecs[i].e_t));
            tick();
        end

        // Backpressure: hold 0xA5 for 5 stalled cycles, offer 0x5A once.
        do_reset();
        step(1'b0, 1'b1, pk(8'hA5), 4'h5, 1'b0);
        for (int unsigned k = 1; k <= 5; k++) begin
            drive(1'b0, k == 1, pk(8'h5A), 4'hA, 1'b0);
            check("bp_q_hold",    32'(q_data[7:0]), 32'hA5);
            check("bp_out_valid", 32'(out_valid),   32'h1);
            check("bp_in_ready",  32'(in_ready),    32'(SKID && (k == 1)));
            check("bp_stall_cnt", 32'(stall_cnt),   k - 1);
            tick();
        end
        drive(1'b0, 1'b0, '0, 4'h0, 1'b1);
        check("bp_cnt5",     32'(stall_cnt),   32'd5);
        check("bp_q_a5",     32'(q_data[7:0]), 32'hA5);
        tick();
        drive(1'b0, 1'b0, '0, 4'h0, 1'b1);
        check("bp_second_ov", 32'(out_valid),   32'(SKID));
        check("bp_second_q",  32'(q_data[7:0]), SKID ? 32'h5A : 32'hA5);
        tick();
        drive(1'b0, 1'b0, '0, 4'h0, 1'b1);
        check("bp_drained_ov", 32'(out_valid), 32'h0);
        tick();

        // Flush with a new word offered and the stage as full as it can be.
        do_reset();
        step(1'b0, 1'b1, pk(8'h66), 4'h6, 1'b0);
        step(1'b0, 1'b1, pk(8'h99), 4'h9, 1'b0);
        drive(1'b1, 1'b1, pk(8'h77), 4'h7, 1'b0);
        check("fl_in_ready", 32'(in_ready), 32'h0);
        tick();
        drive(1'b0, 1'b0, '0, 4'h0, 1'b1);
        check("fl_out_valid", 32'(out_valid),   32'h0);
        check("fl_q_kept",    32'(q_data[7:0]), 32'h66);
        check("fl_tag_kept",  32'(q_tag),       32'h6);
        check("fl_in_ready1", 32'(in_ready),    32'h1);
        tick();
        drive(1'b0, 1'b0, '0, 4'h0, 1'b1);
        check("fl_nothing_emitted", 32'(out_valid), 32'h0);
        tick();

        // Counter saturation, not cleared by flush.
        do_reset();
        step(1'b0, 1'b1, pk(8'h21), 4'h1, 1'b0);
        for (int unsigned k = 0; k < 20; k++) step(1'b0, 1'b0, '0, 4'h0, 1'b0);
        drive(1'b0, 1'b0, '0, 4'h0, 1'b0);
        check("sat_cnt", 32'(stall_cnt), 32'd15);
        tick();
        step(1'b1, 1'b0, '0, 4'h0, 1'b0);
        drive(1'b0, 1'b0, '0, 4'h0, 1'b0);
        check("sat_after_flush", 32'(stall_cnt), 32'd15);
        check("sat_flush_ov",    32'(out_valid), 32'h0);
        tick();

        // Asynchronous reset mid-stall with the stage full.
        do_reset();
        step(1'b0, 1'b1, pk(8'h12), 4'h2, 1'b0);
        step(1'b0, 1'b1, pk(8'h34), 4'h4, 1'b0);
        step(1'b0, 1'b0, '0, 4'h0, 1'b0);
        step(1'b0, 1'b0, '0, 4'h0, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'h0);
        check("arst_stall_cnt", 32'(stall_cnt), 32'h0);
        check("arst_q_data",    32'(q_data),    32'h0);
        check("arst_q_tag",     32'(q_tag),     32'h0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1'b0, 1'b0, '0, 4'h0, 1'b1);
        tick();
        drive(1'b0, 1'b0, '0, 4'h0, 1'b1);
        check("arst_words_lost", 32'(out_valid), 32'h0);
        tick();

        // Randomised traffic against the model.
        do_reset();
        for (int unsigned k = 0; k < 400; k++) begin
            logic [31:0] r;
            logic [31:0] rd;
            r  = $urandom();
            rd = $urandom();
            step(r[3:0] == 4'h0, r[5:4] != 2'b00, rd[DW-1:0], r[11:8], r[13:12] != 2'b00 || r[14]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
